// File: rtl/lc3_seq_ctrl.sv
// Multi-cycle control sequencer for a 16-bit LC-3-style datapath.
// Steps each instruction through fetch, decode, execute, memory and
// writeback, and drives every load strobe and mux select of the datapath.
// Memory accesses wait on a ready handshake and give up after a bounded
// number of stall cycles.
module lc3_seq_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [2:0]       ir_nzp,
  input  logic             ir_imm,
  input  logic [2:0]       cc_nzp,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             ld_ir,
  output logic             ld_pc,
  output logic [1:0]       pc_sel,
  output logic             ld_reg,
  output logic             reg_src,
  output logic             ld_cc,
  output logic [1:0]       alu_op,
  output logic             alu_b_sel,
  output logic             mem_en,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [7:0]       WAIT_LIM = 8'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [7:0]       waitCnt_q, waitCnt_d;

  // Next-state, counters and strobe decode; reset masks every strobe so an
  // in-flight access is abandoned cleanly.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    error_d   = error_q;
    retired_d = retired_q;
    waitCnt_d = waitCnt_q;
    ld_ir     = 1'b0;
    ld_pc     = 1'b0;
    pc_sel    = 2'd0;
    ld_reg    = 1'b0;
    reg_src   = 1'b0;
    ld_cc     = 1'b0;
    alu_op    = 2'd0;
    alu_b_sel = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_en = 1'b1;
        if (mem_ready) begin
          ld_ir     = 1'b1;
          ld_pc     = 1'b1;
          waitCnt_d = 8'd0;
          state_d   = S_DECODE;
        end else if (waitCnt_q == WAIT_LIM) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          error_d  = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP: state_d = S_EXEC;
          OP_LD, OP_ST: begin
            state_d   = S_MEM;
            waitCnt_d = 8'd0;
          end
          OP_TRAP: begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            retired_d = retired_q + CNT_ONE;
          end
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            error_d  = 1'b1;
          end
        endcase
      end

      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND: begin
            ld_reg    = 1'b1;
            ld_cc     = 1'b1;
            alu_op    = (opcode == OP_AND) ? 2'd1 : 2'd0;
            alu_b_sel = ir_imm;
          end
          OP_NOT: begin
            ld_reg = 1'b1;
            ld_cc  = 1'b1;
            alu_op = 2'd2;
          end
          OP_BR: begin
            if ((ir_nzp & cc_nzp) != 3'b000) begin
              ld_pc  = 1'b1;
              pc_sel = 2'd1;
            end
          end
          OP_JMP: begin
            ld_pc  = 1'b1;
            pc_sel = 2'd2;
          end
          default: ;
        endcase
        state_d   = S_FETCH;
        waitCnt_d = 8'd0;
        retired_d = retired_q + CNT_ONE;
      end

      S_MEM: begin
        mem_en   = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_ST);
        if (mem_ready) begin
          waitCnt_d = 8'd0;
          if (opcode == OP_ST) begin
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_ONE;
          end else begin
            state_d = S_WB;
          end
        end else if (waitCnt_q == WAIT_LIM) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          error_d  = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end

      S_WB: begin
        ld_reg    = 1'b1;
        ld_cc     = 1'b1;
        reg_src   = 1'b1;
        state_d   = S_FETCH;
        waitCnt_d = 8'd0;
        retired_d = retired_q + CNT_ONE;
      end

      S_HALT: ;

      default: begin
        state_d  = S_HALT;
        halted_d = 1'b1;
        error_d  = 1'b1;
      end
    endcase

    if (reset) begin
      ld_ir     = 1'b0;
      ld_pc     = 1'b0;
      pc_sel    = 2'd0;
      ld_reg    = 1'b0;
      reg_src   = 1'b0;
      ld_cc     = 1'b0;
      alu_op    = 2'd0;
      alu_b_sel = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
    end
  end

  // State, sticky flags, retire counter and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      error_q   <= 1'b0;
      retired_q <= '0;
      waitCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      error_q   <= error_d;
      retired_q <= retired_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign error   = error_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// Directed, table-driven bench for the LC-3 control sequencer.
module tb_lc3_seq_ctrl;

  typedef struct packed {
    logic       ldIr;
    logic       ldPc;
    logic [1:0] pcSel;
    logic       ldReg;
    logic       regSrc;
    logic       ldCc;
    logic [1:0] aluOp;
    logic       aluBSel;
    logic       memEn;
    logic       memWe;
    logic       addrSel;
  } strb_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  opc;
    logic [2:0]  nzp;
    logic        imm;
    logic [2:0]  cc;
    logic        rdy;
    logic [2:0]  st;
    strb_t       strb;
    logic        hlt;
    logic        err;
    logic [15:0] ret;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [3:0]  opcode;
  logic [2:0]  ir_nzp;
  logic        ir_imm;
  logic [2:0]  cc_nzp;
  logic        mem_ready;
  logic [2:0]  state;
  logic        ld_ir, ld_pc, ld_reg, reg_src, ld_cc, alu_b_sel;
  logic        mem_en, mem_we, addr_sel, halted, error;
  logic [1:0]  pc_sel, alu_op;
  logic [15:0] retired;

  int testsRun    = 0;
  int testsFailed = 0;
  vec_t vecs[$];

  lc3_seq_ctrl #(.CNT_W(16), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .ir_nzp(ir_nzp),
    .ir_imm(ir_imm), .cc_nzp(cc_nzp), .mem_ready(mem_ready),
    .state(state), .ld_ir(ld_ir), .ld_pc(ld_pc), .pc_sel(pc_sel),
    .ld_reg(ld_reg), .reg_src(reg_src), .ld_cc(ld_cc), .alu_op(alu_op),
    .alu_b_sel(alu_b_sel), .mem_en(mem_en), .mem_we(mem_we),
    .addr_sel(addr_sel), .halted(halted), .error(error), .retired(retired)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic strb_t mk(input logic ldIr, input logic ldPc,
                               input logic [1:0] pcSel, input logic ldReg,
                               input logic regSrc, input logic ldCc,
                               input logic [1:0] aluOp, input logic aluBSel,
                               input logic memEn, input logic memWe,
                               input logic addrSel);
    strb_t s;
    s.ldIr = ldIr; s.ldPc = ldPc; s.pcSel = pcSel; s.ldReg = ldReg;
    s.regSrc = regSrc; s.ldCc = ldCc; s.aluOp = aluOp; s.aluBSel = aluBSel;
    s.memEn = memEn; s.memWe = memWe; s.addrSel = addrSel;
    return s;
  endfunction

  task automatic addVec(input string name, input logic rst, input logic [3:0] opc,
                        input logic [2:0] nzp, input logic imm, input logic [2:0] cc,
                        input logic rdy, input logic [2:0] st, input strb_t strb,
                        input logic hlt, input logic err, input logic [15:0] ret);
    vec_t v;
    v.name = name; v.rst = rst; v.opc = opc; v.nzp = nzp; v.imm = imm;
    v.cc = cc; v.rdy = rdy; v.st = st; v.strb = strb; v.hlt = hlt;
    v.err = err; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] opc,
                               input logic [2:0] nzp, input logic imm,
                               input logic [2:0] cc, input logic rdy);
    reset = rst; opcode = opc; ir_nzp = nzp; ir_imm = imm;
    cc_nzp = cc; mem_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] st,
                             input strb_t strb, input logic hlt,
                             input logic err, input logic [15:0] ret);
    strb_t got;
    got = mk(ld_ir, ld_pc, pc_sel, ld_reg, reg_src, ld_cc, alu_op,
             alu_b_sel, mem_en, mem_we, addr_sel);
    testsRun++;
    if (state !== st || got !== strb || halted !== hlt ||
        error !== err || retired !== ret) begin
      testsFailed++;
      $display("[TB] FAIL %s: got state=%0d strb=%h halted=%b error=%b retired=%0d, expected state=%0d strb=%h halted=%b error=%b retired=%0d",
               name, state, got, halted, error, retired, st, strb, hlt, err, ret);
    end
  endtask

  // One clock cycle: drive just after the edge, check at the falling edge.
  task automatic cycle(input string name, input logic rst, input logic [3:0] opc,
                       input logic [2:0] nzp, input logic imm, input logic [2:0] cc,
                       input logic rdy, input logic [2:0] st, input strb_t strb,
                       input logic hlt, input logic err, input logic [15:0] ret);
    applyStimulus(rst, opc, nzp, imm, cc, rdy);
    @(negedge clk);
    checkOutput(name, st, strb, hlt, err, ret);
    @(posedge clk);
    #1;
  endtask

  task automatic runTable();
    foreach (vecs[i])
      cycle(vecs[i].name, vecs[i].rst, vecs[i].opc, vecs[i].nzp, vecs[i].imm,
            vecs[i].cc, vecs[i].rdy, vecs[i].st, vecs[i].strb, vecs[i].hlt,
            vecs[i].err, vecs[i].ret);
    vecs.delete();
  endtask

  // Directed instruction sequences, corner cases and the final summary.
  initial begin
    strb_t sZ, sFR, sFW, sMemLd, sMemSt, sWb, sBr, sJmp;
    sZ     = '0;
    sFR    = mk(1, 1, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
    sFW    = mk(0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
    sMemLd = mk(0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0, 1);
    sMemSt = mk(0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 1, 1);
    sWb    = mk(0, 0, 2'd0, 1, 1, 1, 2'd0, 0, 0, 0, 0);
    sBr    = mk(0, 1, 2'd1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    sJmp   = mk(0, 1, 2'd2, 0, 0, 0, 2'd0, 0, 0, 0, 0);

    applyStimulus(1, 4'b0001, 3'b000, 0, 3'b000, 1);
    @(posedge clk);
    #1;

    // Reset, then ADD imm / AND reg / NOT / BR not-taken / BR taken / JMP.
    addVec("reset",       1, 4'b0001, 3'b000, 1, 3'b000, 1, 3'd0, sZ,  0, 0, 0);
    addVec("add_fetch",   0, 4'b0001, 3'b000, 1, 3'b000, 1, 3'd0, sFR, 0, 0, 0);
    addVec("add_decode",  0, 4'b0001, 3'b000, 1, 3'b000, 1, 3'd1, sZ,  0, 0, 0);
    addVec("add_exec",    0, 4'b0001, 3'b000, 1, 3'b000, 1, 3'd2,
           mk(0, 0, 2'd0, 1, 0, 1, 2'd0, 1, 0, 0, 0), 0, 0, 0);
    addVec("and_fetch",   0, 4'b0101, 3'b000, 0, 3'b000, 1, 3'd0, sFR, 0, 0, 1);
    addVec("and_decode",  0, 4'b0101, 3'b000, 0, 3'b000, 1, 3'd1, sZ,  0, 0, 1);
    addVec("and_exec",    0, 4'b0101, 3'b000, 0, 3'b000, 1, 3'd2,
           mk(0, 0, 2'd0, 1, 0, 1, 2'd1, 0, 0, 0, 0), 0, 0, 1);
    addVec("not_fetch",   0, 4'b1001, 3'b000, 1, 3'b000, 1, 3'd0, sFR, 0, 0, 2);
    addVec("not_decode",  0, 4'b1001, 3'b000, 1, 3'b000, 1, 3'd1, sZ,  0, 0, 2);
    addVec("not_exec",    0, 4'b1001, 3'b000, 1, 3'b000, 1, 3'd2,
           mk(0, 0, 2'd0, 1, 0, 1, 2'd2, 0, 0, 0, 0), 0, 0, 2);
    addVec("brnt_fetch",  0, 4'b0000, 3'b010, 0, 3'b001, 1, 3'd0, sFR, 0, 0, 3);
    addVec("brnt_decode", 0, 4'b0000, 3'b010, 0, 3'b001, 1, 3'd1, sZ,  0, 0, 3);
    addVec("brnt_exec",   0, 4'b0000, 3'b010, 0, 3'b001, 1, 3'd2, sZ,  0, 0, 3);
    addVec("brt_fetch",   0, 4'b0000, 3'b010, 0, 3'b010, 1, 3'd0, sFR, 0, 0, 4);
    addVec("brt_decode",  0, 4'b0000, 3'b010, 0, 3'b010, 1, 3'd1, sZ,  0, 0, 4);
    addVec("brt_exec",    0, 4'b0000, 3'b010, 0, 3'b010, 1, 3'd2, sBr, 0, 0, 4);
    addVec("jmp_fetch",   0, 4'b1100, 3'b000, 0, 3'b000, 1, 3'd0, sFR, 0, 0, 5);
    addVec("jmp_decode",  0, 4'b1100, 3'b000, 0, 3'b000, 1, 3'd1, sZ,  0, 0, 5);
    addVec("jmp_exec",    0, 4'b1100, 3'b000, 0, 3'b000, 1, 3'd2, sJmp, 0, 0, 5);
    // LD with three stall cycles in MEM, then ST, then fetch stalls.
    addVec("ld_fetch",    0, 4'b0010, 3'b000, 0, 3'b000, 1, 3'd0, sFR, 0, 0, 6);
    addVec("ld_decode",   0, 4'b0010, 3'b000, 0, 3'b000, 0, 3'd1, sZ,  0, 0, 6);
    addVec("ld_mem_w1",   0, 4'b0010, 3'b000, 0, 3'b000, 0, 3'd3, sMemLd, 0, 0, 6);
    addVec("ld_mem_w2",   0, 4'b0010, 3'b000, 0, 3'b000, 0, 3'd3, sMemLd, 0, 0, 6);
    addVec("ld_mem_w3",   0, 4'b0010, 3'b000, 0, 3'b000, 0, 3'd3, sMemLd, 0, 0, 6);
    addVec("ld_mem_rdy",  0, 4'b0010, 3'b000, 0, 3'b000, 1, 3'd3, sMemLd, 0, 0, 6);
    addVec("ld_wb",       0, 4'b0010, 3'b000, 0, 3'b000, 1, 3'd4, sWb, 0, 0, 6);
    addVec("st_fetch",    0, 4'b0011, 3'b000, 0, 3'b000, 1, 3'd0, sFR, 0, 0, 7);
    addVec("st_decode",   0, 4'b0011, 3'b000, 0, 3'b000, 1, 3'd1, sZ,  0, 0, 7);
    addVec("st_mem",      0, 4'b0011, 3'b000, 0, 3'b000, 1, 3'd3, sMemSt, 0, 0, 7);
    addVec("fw_stall1",   0, 4'b0001, 3'b000, 0, 3'b000, 0, 3'd0, sFW, 0, 0, 8);
    addVec("fw_stall2",   0, 4'b0001, 3'b000, 0, 3'b000, 0, 3'd0, sFW, 0, 0, 8);
    addVec("fw_ready",    0, 4'b0001, 3'b000, 0, 3'b000, 1, 3'd0, sFR, 0, 0, 8);
    addVec("fw_decode",   0, 4'b0001, 3'b000, 0, 3'b000, 1, 3'd1, sZ,  0, 0, 8);
    addVec("fw_exec",     0, 4'b0001, 3'b000, 0, 3'b000, 1, 3'd2,
           mk(0, 0, 2'd0, 1, 0, 1, 2'd0, 0, 0, 0, 0), 0, 0, 8);
    addVec("trap_fetch",  0, 4'b1111, 3'b000, 0, 3'b000, 1, 3'd0, sFR, 0, 0, 9);
    addVec("trap_decode", 0, 4'b1111, 3'b000, 0, 3'b000, 1, 3'd1, sZ,  0, 0, 9);
    addVec("trap_halt",   0, 4'b1111, 3'b000, 0, 3'b000, 1, 3'd5, sZ,  1, 0, 10);
    runTable();

    // HALT is absorbing: mem_ready and opcodes must not wake it.
    for (int i = 0; i < 20; i++)
      cycle("halt_idle", 0, 4'(i), 3'b111, 1, 3'b111, 1, 3'd5, sZ, 1, 0, 10);

    // Reset out of HALT, illegal opcode, then reset mid-way through a stalled ST.
    addVec("rst_halt",    1, 4'b1101, 3'b000, 0, 3'b000, 1, 3'd5, sZ,  1, 0, 10);
    addVec("ill_fetch",   0, 4'b1101, 3'b000, 0, 3'b000, 1, 3'd0, sFR, 0, 0, 0);
    addVec("ill_decode",  0, 4'b1101, 3'b000, 0, 3'b000, 1, 3'd1, sZ,  0, 0, 0);
    addVec("ill_halt",    0, 4'b1101, 3'b000, 0, 3'b000, 1, 3'd5, sZ,  1, 1, 0);
    addVec("rst_ill",     1, 4'b0011, 3'b000, 0, 3'b000, 1, 3'd5, sZ,  1, 1, 0);
    addVec("sta_fetch",   0, 4'b0011, 3'b000, 0, 3'b000, 1, 3'd0, sFR, 0, 0, 0);
    addVec("sta_decode",  0, 4'b0011, 3'b000, 0, 3'b000, 0, 3'd1, sZ,  0, 0, 0);
    addVec("sta_mem_w1",  0, 4'b0011, 3'b000, 0, 3'b000, 0, 3'd3, sMemSt, 0, 0, 0);
    addVec("sta_mem_rst", 1, 4'b0011, 3'b000, 0, 3'b000, 0, 3'd3, sZ,  0, 0, 0);
    addVec("sta_refetch", 0, 4'b0011, 3'b000, 0, 3'b000, 0, 3'd0, sFW, 0, 0, 0);
    runTable();

    // Fetch timeout: 16 stalled FETCH cycles in total, then HALT with error.
    for (int i = 1; i < 16; i++)
      cycle("to_fetch", 0, 4'b0001, 3'b000, 0, 3'b000, 0, 3'd0, sFW, 0, 0, 0);
    cycle("to_halt", 0, 4'b0001, 3'b000, 0, 3'b000, 0, 3'd5, sZ, 1, 1, 0);
    cycle("to_rst", 1, 4'b1111, 3'b000, 0, 3'b000, 0, 3'd5, sZ, 1, 1, 0);

    // Ready arriving exactly when the stall count hits the limit still succeeds.
    for (int i = 0; i < 15; i++)
      cycle("edge_stall", 0, 4'b1111, 3'b000, 0, 3'b000, 0, 3'd0, sFW, 0, 0, 0);
    cycle("edge_ready",  0, 4'b1111, 3'b000, 0, 3'b000, 1, 3'd0, sFR, 0, 0, 0);
    cycle("edge_decode", 0, 4'b1111, 3'b000, 0, 3'b000, 1, 3'd1, sZ,  0, 0, 0);
    cycle("edge_halt",   0, 4'b1111, 3'b000, 0, 3'b000, 1, 3'd5, sZ,  1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lc3_seq_ctrl.md
Name: lc3_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 16-bit LC-3-style datapath: PC, IR, 8x16 register file, ALU, unified memory.
- Walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives every load strobe and mux select of the datapath.
- Handshakes with memory through a ready signal and a bounded wait timeout.
- Instantiated inside the CPU top beside the datapath; this replaces single-cycle operation.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- WAIT_MAX, 15, maximum cycles spent waiting for mem_ready in one access before a fatal timeout (1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12], valid from DECODE onward.
- ir_nzp  in  3  IR[11:9], branch condition mask.
- ir_imm  in  1  IR[5], immediate-mode flag for ADD/AND.
- cc_nzp  in  3  current condition-code register {N,Z,P}.
- mem_ready  in  1  memory completes the current access this cycle.
- state  out  3  current state encoding.
- ld_ir  out  1  load IR from mem data.
- ld_pc  out  1  load PC.
- pc_sel  out  2  PC source: 0=PC+1, 1=PC+1+sext(off9), 2=BaseR.
- ld_reg  out  1  register-file write enable, DR.
- reg_src  out  1  writeback source: 0=ALU, 1=mem data.
- ld_cc  out  1  update condition codes from writeback value.
- alu_op  out  2  0=ADD, 1=AND, 2=NOT, 3=PASS_A.
- alu_b_sel  out  1  0=SR2, 1=sext(imm5).
- mem_en  out  1  memory access request.
- mem_we  out  1  memory write; valid only with mem_en.
- addr_sel  out  1  memory address: 0=PC, 1=PC+1+sext(off9).
- halted  out  1  sticky; core stopped.
- error  out  1  sticky; halt caused by timeout or illegal opcode.
- retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- Interface: clk is the only clock. reset is synchronous, active-high, and is sampled on the rising edge of clk.
- Registered outputs: state, halted, error, retired, wait counter.
  - Reset value: state=FETCH, halted=0, error=0, retired=0, wait=0.
- Combinational outputs: all strobes and selects are decoded from state, opcode, mem_ready and cc_nzp.
  - All are forced to 0 while reset=1.
  - All are 0 in any state or condition not listed below.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to HALT with error=1.
- FETCH:
  - Outputs: mem_en=1, addr_sel=0.
  - On mem_ready=1: ld_ir=1, ld_pc=1, pc_sel=0, then go to DECODE.
  - On mem_ready=0: stay and increment wait.
- DECODE (1 cycle, no strobes), next state by opcode:
  - 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP: EXEC.
  - 0010 LD, 0011 ST: MEM.
  - 1111 TRAP: HALT with error=0.
  - Any other opcode: HALT with error=1.
- EXEC (1 cycle, then FETCH):
  - ADD, AND: ld_reg=1, ld_cc=1, reg_src=0, alu_op=0 or 1, alu_b_sel=ir_imm.
  - NOT: same as ADD/AND but alu_op=2, alu_b_sel=0.
  - BR: if (ir_nzp & cc_nzp)!=0 then ld_pc=1, pc_sel=1; otherwise no strobe.
  - JMP: ld_pc=1, pc_sel=2.
- MEM:
  - Outputs: mem_en=1, addr_sel=1, mem_we=1 for ST.
  - On mem_ready: ST goes to FETCH; LD goes to WB.
  - Otherwise stay and increment wait.
- WB (1 cycle, then FETCH): ld_reg=1, ld_cc=1, reg_src=1.
- Wait counter:
  - Cleared on entry to FETCH or MEM and whenever mem_ready=1.
  - If wait==WAIT_MAX and mem_ready=0: go to HALT, error=1, and drop mem_en the following cycle.
  - mem_ready asserted on the cycle wait reaches WAIT_MAX counts as success.
- retired increments by 1 on the final cycle of each instruction:
  - EXEC exit.
  - WB.
  - MEM exit for ST.
  - The DECODE cycle of TRAP.
  - Not incremented for an illegal opcode or a timeout.
- Latency with zero-wait memory: ALU/BR/JMP=3 cycles, ST=3, LD=4. Each wait cycle adds 1.
- HALT: absorbing state, all strobes 0. Only reset leaves it.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-access (any state) aborts the access: state=FETCH and all strobes 0 in the reset cycle.

Test Plan:
- ADD R1,R1,#3 (opcode 0001, ir_imm=1), mem_ready=1 always -> states 0,1,2,0 over 3 cycles; ld_ir and ld_pc in cycle 0; ld_reg=1, ld_cc=1, alu_b_sel=1, alu_op=0 in cycle 2; retired 0->1.
- LD with mem_ready low for 3 cycles in MEM -> MEM lasts 4 cycles with mem_en=1, mem_we=0, addr_sel=1; WB asserts reg_src=1, ld_reg=1; total 7 cycles; retired +1.
- BR with ir_nzp=3'b010: cc_nzp=3'b001 -> no ld_pc in EXEC; cc_nzp=3'b010 -> ld_pc=1, pc_sel=1.
- TRAP (1111) after 2 instructions -> HALT, halted=1, error=0, retired=3; 20 further cycles show no strobes.
- mem_ready held 0 in FETCH with WAIT_MAX=15 -> HALT after 16 FETCH cycles; error=1; retired unchanged.
- Opcode 1101 -> HALT with error=1. Then reset high for 1 cycle -> state=0, halted=0, error=0, retired=0.
- Reset asserted in the 2nd cycle of a stalled ST MEM access -> next state FETCH; mem_we=0 during reset; no retired increment.
